mult_request_scheduler: RTL and testbench
=========================================

Name: mult_request_scheduler

Overview:
Sequencing and arbitration front-end for the small-factor multiplier datapath on the TT02 tile. Two requesters share one sequential shift-add multiplier through a round-robin arbiter. Each accepted operand pair is multiplied over WIDTH cycles. The latest product is shown as two time-multiplexed decimal digits on the 7-segment output, with a digit-select flag, so the io_out mapping (segments plus lsb-digit flag) is unchanged.

Parameters:
WIDTH, 3, factor width in bits; legal range 1..3, so the product is at most 49 and always fits two decimal digits
REFRESH_CYCLES, 4, clock cycles each digit is held on o_segments before the display switches digit; minimum 1

Ports:
clk  input  1  single system clock, rising edge
reset  input  1  synchronous, active-high reset
i_req_a  input  1  requester A wants a multiply; held high until o_gnt_a
i_a_factor_a  input  WIDTH  requester A operand 1; held stable with i_req_a
i_a_factor_b  input  WIDTH  requester A operand 2
i_req_b  input  1  requester B request
i_b_factor_a  input  WIDTH  requester B operand 1
i_b_factor_b  input  WIDTH  requester B operand 2
o_gnt_a  output  1  one-cycle pulse: A's operands captured
o_gnt_b  output  1  one-cycle pulse: B's operands captured
o_busy  output  1  high while in CALC
o_done  output  1  one-cycle pulse: o_product updated
o_owner  output  1  requester owning o_product (0=A, 1=B)
o_product  output  2*WIDTH  last completed product
o_segments  output  7  active-high 7-seg pattern; bit0=a .. bit6=g
o_lsb_digit  output  1  1 = units digit shown, 0 = tens digit shown

Behaviour:
- Reset values: state IDLE; o_gnt_a, o_gnt_b, o_busy, o_done = 0; o_owner = 0; o_product = 0; last-grant pointer = B; refresh counter = 0; o_lsb_digit = 1; o_segments = 7'h3F (digit 0).
- All outputs are registered.
- FSM states: IDLE and CALC.
- IDLE:
  - At each edge, sample i_req_a and i_req_b.
  - If only one is high, grant it.
  - If both are high, grant the requester that is not the last-grant pointer. After reset, A wins the first tie.
  - On grant: latch that requester's operands, set o_gnt_x = 1 for exactly the next cycle, update the pointer and o_owner-pending, and go to CALC with step counter = 0.
  - If neither request is high, remain in IDLE.
- CALC:
  - One shift-add step per edge: if multiplier bit[step] = 1, add the multiplicand shifted left by step into the accumulator.
  - After the WIDTH-th step edge, write the accumulator to o_product, update o_owner, pulse o_done for one cycle, and return to IDLE.
  - o_busy = 1 for all WIDTH cycles in CALC.
  - Requests are ignored while in CALC.
- Timing: request sampled at edge E0 -> o_gnt high during cycle E0..E1 -> o_done and new o_product visible after edge E0+WIDTH. The earliest next grant edge is E0+WIDTH+1, giving a throughput of one product per WIDTH+1 cycles.
- A requester still asserting req after its gnt is treated as a new request.
- Display:
  - Refresh counter runs 0..REFRESH_CYCLES-1 and wraps. o_lsb_digit toggles on each wrap.
  - Displayed digit: tens = o_product/10 when o_lsb_digit = 0; units = o_product%10 when o_lsb_digit = 1.
  - o_segments is registered and takes the new digit/product on the following edge.
  - Encoding: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
  - The display runs independently of the FSM and is never stalled by CALC.
- Reset mid-CALC: the operation is abandoned, with no o_done, and every register returns to its reset value on that edge.
- Reset overrides simultaneous requests.

Optional Feature:
MULT_SCHED_ZERO_SKIP_EN:
- Defined: if either latched operand is 0, CALC lasts 1 cycle; o_product = 0 and o_done pulses after edge E0+1.
- Undefined: CALC always lasts WIDTH cycles regardless of operand values.

Test Plan:
1. Assert reset 2 cycles -> o_product = 0, o_segments = 3F, o_lsb_digit = 1, o_busy = 0, o_gnt_a = o_gnt_b = 0.
2. Requester A only, 3x5 -> o_gnt_a for 1 cycle; o_done 3 cycles later; o_product = 15, o_owner = 0; display alternates 6D (units) and 06 (tens) every 4 cycles.
3. A (7x7) and B (2x3) requested at the same edge -> A granted first, product 49 (segments 6F/66); o_gnt_b 4 cycles after o_gnt_a; second product 6, o_owner = 1, tens shows 3F.
4. Both requests held high continuously -> grant order A, B, A, B; o_done every 4 cycles.
5. Reset asserted 2 cycles into CALC -> no o_done, o_product = 0, IDLE next cycle; a new A request afterwards is served normally.
6. A request 0x6: with MULT_SCHED_ZERO_SKIP_EN -> o_done 1 cycle after the grant edge; without -> 3 cycles; o_product = 0 in both cases.

Source files
------------

// File: rtl/mult_request_scheduler.sv
// mult_request_scheduler: two-requester round-robin front-end for a sequential
// shift-add multiplier, with a two-digit time-multiplexed 7-segment display of
// the last product.
// Optional build macro: MULT_SCHED_ZERO_SKIP_EN (finishes CALC after one cycle
// when either latched operand is zero).
module mult_request_scheduler #(
  parameter int unsigned WIDTH          = 3,
  parameter int unsigned REFRESH_CYCLES = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_req_a,
  input  logic [WIDTH-1:0]   i_a_factor_a,
  input  logic [WIDTH-1:0]   i_a_factor_b,
  input  logic               i_req_b,
  input  logic [WIDTH-1:0]   i_b_factor_a,
  input  logic [WIDTH-1:0]   i_b_factor_b,
  output logic               o_gnt_a,
  output logic               o_gnt_b,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_owner,
  output logic [2*WIDTH-1:0] o_product,
  output logic [6:0]         o_segments,
  output logic               o_lsb_digit
);

  localparam int unsigned PW     = 2 * WIDTH;
  localparam int unsigned STEP_W = 2;
  localparam int unsigned CNT_W  = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;

  typedef enum logic {IDLE = 1'b0, CALC = 1'b1} state_t;

  state_t            state;
  state_t            next_state;
  logic              last_b;
  logic              owner_pend;
  logic [WIDTH-1:0]  mplier;
  logic [PW-1:0]     mcand;
  logic [PW-1:0]     acc;
  logic [STEP_W-1:0] step;
  logic              zero_op;
  logic [CNT_W-1:0]  refresh_cnt;

  logic              grant_a_c;
  logic              grant_b_c;
  logic              last_step_c;
  logic [PW-1:0]     acc_next_c;
  logic [PW-1:0]     product_c;
  logic [3:0]        digit_c;
  logic [31:0]       prod32_c;

  // 7-segment pattern for one decimal digit (bit0=a .. bit6=g)
  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (grant_a_c || grant_b_c) next_state = CALC;
      CALC:    if (last_step_c) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Arbitration and shift-add step decode; a tie goes to whoever was not granted last
  always_comb begin
    grant_a_c   = 1'b0;
    grant_b_c   = 1'b0;
    if (state == IDLE) begin
      if (i_req_a && (!i_req_b || last_b)) grant_a_c = 1'b1;
      else if (i_req_b)                    grant_b_c = 1'b1;
    end
    acc_next_c  = acc + (mplier[0] ? mcand : PW'(0));
`ifdef MULT_SCHED_ZERO_SKIP_EN
    last_step_c = (state == CALC) && ((step == STEP_W'(WIDTH - 1)) || zero_op);
    product_c   = zero_op ? PW'(0) : acc_next_c;
`else
    last_step_c = (state == CALC) && (step == STEP_W'(WIDTH - 1));
    product_c   = acc_next_c;
`endif
  end

  // Operand capture, multiplier datapath and registered handshake outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      o_gnt_a    <= 1'b0;
      o_gnt_b    <= 1'b0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
      o_owner    <= 1'b0;
      o_product  <= '0;
      last_b     <= 1'b1;
      owner_pend <= 1'b0;
      mplier     <= '0;
      mcand      <= '0;
      acc        <= '0;
      step       <= '0;
      zero_op    <= 1'b0;
    end else begin
      o_gnt_a <= grant_a_c;
      o_gnt_b <= grant_b_c;
      o_done  <= last_step_c;
      o_busy  <= (next_state == CALC);
      if (grant_a_c || grant_b_c) begin
        mplier     <= grant_a_c ? i_a_factor_b : i_b_factor_b;
        mcand      <= PW'(grant_a_c ? i_a_factor_a : i_b_factor_a);
        zero_op    <= grant_a_c ? ((i_a_factor_a == '0) || (i_a_factor_b == '0))
                                : ((i_b_factor_a == '0) || (i_b_factor_b == '0));
        acc        <= '0;
        step       <= '0;
        last_b     <= grant_b_c;
        owner_pend <= grant_b_c;
      end else if (state == CALC) begin
        acc    <= acc_next_c;
        mplier <= mplier >> 1;
        mcand  <= mcand << 1;
        step   <= step + STEP_W'(1);
        if (last_step_c) begin
          o_product <= product_c;
          o_owner   <= owner_pend;
        end
      end
    end
  end

  // Digit selected by the current display phase
  always_comb begin
    prod32_c = 32'(o_product);
    digit_c  = o_lsb_digit ? 4'(prod32_c % 32'd10) : 4'(prod32_c / 32'd10);
  end

  // Display refresh: hold each digit REFRESH_CYCLES cycles, segments lag one edge
  always_ff @(posedge clk) begin
    if (reset) begin
      refresh_cnt <= '0;
      o_lsb_digit <= 1'b1;
      o_segments  <= 7'h3F;
    end else begin
      if (refresh_cnt == CNT_W'(REFRESH_CYCLES - 1)) begin
        refresh_cnt <= '0;
        o_lsb_digit <= ~o_lsb_digit;
      end else begin
        refresh_cnt <= refresh_cnt + CNT_W'(1);
      end
      o_segments <= seg7(digit_c);
    end
  end

endmodule

// File: tb/tb_mult_request_scheduler.sv
// Self-checking bench for mult_request_scheduler: a transaction-level model is
// checked every cycle, plus a vector table and directed corner sequences.
module tb_mult_request_scheduler;

  localparam int unsigned WIDTH          = 3;
  localparam int unsigned REFRESH_CYCLES = 4;
  localparam int unsigned PW             = 2 * WIDTH;
`ifdef MULT_SCHED_ZERO_SKIP_EN
  localparam int ZS_LAT = 1;
`else
  localparam int ZS_LAT = WIDTH;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic             req_a, req_b;
  logic [WIDTH-1:0] a_fa, a_fb, b_fa, b_fb;
  logic             gnt_a, gnt_b, busy, done, owner, lsb_digit;
  logic [PW-1:0]    product;
  logic [6:0]       segments;

  always #5 clk = ~clk;

  mult_request_scheduler #(.WIDTH(WIDTH), .REFRESH_CYCLES(REFRESH_CYCLES)) dut (
    .clk(clk), .reset(reset),
    .i_req_a(req_a), .i_a_factor_a(a_fa), .i_a_factor_b(a_fb),
    .i_req_b(req_b), .i_b_factor_a(b_fa), .i_b_factor_b(b_fb),
    .o_gnt_a(gnt_a), .o_gnt_b(gnt_b), .o_busy(busy), .o_done(done),
    .o_owner(owner), .o_product(product), .o_segments(segments),
    .o_lsb_digit(lsb_digit)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // reference model: remaining-cycle countdown and product from plain a*b
  int m_calc, m_rem, m_res, m_pend, m_last, m_cyc;
  int e_gnt_a, e_gnt_b, e_busy, e_done, e_owner, e_product, e_lsb, e_seg;

  function automatic int enc(input int d);
    int tab [10];
    tab = '{'h3F, 'h06, 'h5B, 'h4F, 'h66, 'h6D, 'h7D, 'h07, 'h7F, 'h6F};
    return tab[d];
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_calc = 0; m_rem = 0; m_res = 0; m_pend = 0; m_last = 1; m_cyc = 0;
    e_gnt_a = 0; e_gnt_b = 0; e_busy = 0; e_done = 0; e_owner = 0;
    e_product = 0; e_lsb = 1; e_seg = 'h3F;
  endtask

  task automatic start_job(input int who, input int x, input int y);
    m_calc = 1;
    m_res  = x * y;
    m_rem  = (x == 0 || y == 0) ? ZS_LAT : WIDTH;
    m_last = who;
    m_pend = who;
    if (who == 0) e_gnt_a = 1; else e_gnt_b = 1;
  endtask

  // predict outputs after the coming edge from the inputs presently driven
  task automatic model_step();
    int pp, pl;
    if (reset) begin
      model_reset();
      return;
    end
    pp = e_product; pl = e_lsb;
    e_gnt_a = 0; e_gnt_b = 0; e_done = 0;
    if (m_calc == 0) begin
      if (req_a && req_b) begin
        if (m_last == 1) start_job(0, int'(a_fa), int'(a_fb));
        else             start_job(1, int'(b_fa), int'(b_fb));
      end else if (req_a) start_job(0, int'(a_fa), int'(a_fb));
      else if (req_b)     start_job(1, int'(b_fa), int'(b_fb));
    end else begin
      m_rem--;
      if (m_rem == 0) begin
        m_calc = 0; e_done = 1; e_product = m_res; e_owner = m_pend;
      end
    end
    e_busy = m_calc;
    m_cyc++;
    e_lsb = ((m_cyc / REFRESH_CYCLES) % 2 == 0) ? 1 : 0;
    e_seg = enc(pl != 0 ? pp % 10 : pp / 10);
  endtask

  task automatic check_all();
    chk("gnt_a",    int'(gnt_a),     e_gnt_a);
    chk("gnt_b",    int'(gnt_b),     e_gnt_b);
    chk("busy",     int'(busy),      e_busy);
    chk("done",     int'(done),      e_done);
    chk("owner",    int'(owner),     e_owner);
    chk("product",  int'(product),   e_product);
    chk("lsb",      int'(lsb_digit), e_lsb);
    chk("segments", int'(segments),  e_seg);
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  // one request from a single requester, returns product/owner and grant-to-done cycles
  task automatic run_one(input bit use_b, input int x, input int y,
                         output int prod, output int own, output int lat);
    int k;
    if (use_b) begin req_b = 1; b_fa = WIDTH'(x); b_fb = WIDTH'(y); end
    else       begin req_a = 1; a_fa = WIDTH'(x); a_fb = WIDTH'(y); end
    k = 0;
    do begin cycle(); k++; end while (!(use_b ? gnt_b : gnt_a) && k < 20);
    chk("granted", int'(use_b ? gnt_b : gnt_a), 1);
    req_a = 0; req_b = 0;
    k = 0;
    do begin cycle(); k++; end while (!done && k < 20);
    chk("done_seen", int'(done), 1);
    prod = int'(product); own = int'(owner); lat = k;
  endtask

  typedef struct {
    bit use_b;
    int x;
    int y;
    int prod;
    int own;
  } vec_t;

  initial begin
    vec_t tbl [8];
    int   p, o, l, ga, gb, nd;
    int   dprod [2];
    int   down  [2];
    int   order [$];

    reset = 1; req_a = 0; req_b = 0;
    a_fa = '0; a_fb = '0; b_fa = '0; b_fb = '0;
    model_reset();
    @(negedge clk);

    // reset state
    cycle(); cycle();
    chk("rst_product", int'(product), 0);
    chk("rst_segments", int'(segments), 'h3F);
    chk("rst_lsb", int'(lsb_digit), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_gnt", int'({gnt_a, gnt_b}), 0);
    reset = 0;

    // simultaneous requests: A wins first tie, B one product later
    req_a = 1; a_fa = 3'd7; a_fb = 3'd7;
    req_b = 1; b_fa = 3'd2; b_fb = 3'd3;
    ga = -1; gb = -1; nd = 0; dprod = '{0, 0}; down = '{0, 0};
    for (int k = 0; k < 30 && nd < 2; k++) begin
      cycle();
      if (gnt_a) begin ga = k; req_a = 0; end
      if (gnt_b) begin gb = k; req_b = 0; end
      if (done) begin dprod[nd] = int'(product); down[nd] = int'(owner); nd++; end
    end
    chk("tie_a_first", ga, 0);
    chk("tie_gap", gb - ga, WIDTH + 1);
    chk("tie_prod0", dprod[0], 49);
    chk("tie_own0", down[0], 0);
    chk("tie_prod1", dprod[1], 6);
    chk("tie_own1", down[1], 1);
    for (int k = 0; k < 2 * REFRESH_CYCLES + 2; k++) cycle();

    // both held continuously: strict alternation
    req_a = 1; a_fa = 3'd5; a_fb = 3'd6;
    req_b = 1; b_fa = 3'd4; b_fb = 3'd3;
    for (int k = 0; k < 4 * (WIDTH + 1); k++) begin
      cycle();
      if (gnt_a) order.push_back(0);
      if (gnt_b) order.push_back(1);
    end
    req_a = 0; req_b = 0;
    chk("rr_count", order.size(), 4);
    for (int k = 0; k < 4 && k < order.size(); k++) chk("rr_order", order[k], k % 2);
    for (int k = 0; k < WIDTH + 2; k++) cycle();

    // reset in the middle of CALC
    req_a = 1; a_fa = 3'd3; a_fb = 3'd5;
    for (int k = 0; k < 10 && !gnt_a; k++) cycle();
    chk("mid_granted", int'(gnt_a), 1);
    req_a = 0;
    cycle();
    reset = 1; cycle();
    chk("mid_no_done", int'(done), 0);
    chk("mid_product", int'(product), 0);
    reset = 0; cycle();
    chk("mid_idle", int'(busy), 0);
    run_one(0, 3, 5, p, o, l);
    chk("after_rst_prod", p, 15);

    // zero operand latency
    run_one(0, 0, 6, p, o, l);
    chk("zero_prod", p, 0);
    chk("zero_lat", l, ZS_LAT);

    // vector table
    tbl[0] = '{0, 3, 5, 15, 0};
    tbl[1] = '{1, 2, 3, 6, 1};
    tbl[2] = '{0, 7, 7, 49, 0};
    tbl[3] = '{1, 0, 6, 0, 1};
    tbl[4] = '{0, 6, 0, 0, 0};
    tbl[5] = '{1, 7, 1, 7, 1};
    tbl[6] = '{0, 1, 1, 1, 0};
    tbl[7] = '{1, 5, 7, 35, 1};
    for (int i = 0; i < 8; i++) begin
      run_one(tbl[i].use_b, tbl[i].x, tbl[i].y, p, o, l);
      chk("tbl_prod", p, tbl[i].prod);
      chk("tbl_owner", o, tbl[i].own);
      chk("tbl_lat", l, (tbl[i].x == 0 || tbl[i].y == 0) ? ZS_LAT : WIDTH);
      for (int k = 0; k < 3; k++) cycle();
    end

    // randomized traffic against the model
    for (int k = 0; k < 600; k++) begin
      reset = ($urandom_range(0, 99) == 0);
      if (!req_a) begin
        req_a = 1'($urandom_range(0, 1));
        a_fa = WIDTH'($urandom); a_fb = WIDTH'($urandom);
      end
      if (!req_b) begin
        req_b = 1'($urandom_range(0, 1));
        b_fa = WIDTH'($urandom); b_fb = WIDTH'($urandom);
      end
      cycle();
      if (gnt_a) req_a = 0;
      if (gnt_b) req_b = 0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
